// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone-style slave port between two masters,
// with a per-transaction watchdog that ends a hung access with an error pulse.
module mem_bus_arbiter #(
   parameter int ADDRESS_LENGTH = 32,
   parameter int DATA_LENGTH    = 32,
   parameter int TIMEOUT        = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      m0_req,
   input  logic                      m0_we,
   input  logic [ADDRESS_LENGTH-1:0] m0_adr,
   input  logic [DATA_LENGTH-1:0]    m0_wdata,
   output logic [DATA_LENGTH-1:0]    m0_rdata,
   output logic                      m0_ack,
   output logic                      m0_err,
   input  logic                      m1_req,
   input  logic                      m1_we,
   input  logic [ADDRESS_LENGTH-1:0] m1_adr,
   input  logic [DATA_LENGTH-1:0]    m1_wdata,
   output logic [DATA_LENGTH-1:0]    m1_rdata,
   output logic                      m1_ack,
   output logic                      m1_err,
   output logic                      s_cyc,
   output logic                      s_we,
   output logic [ADDRESS_LENGTH-1:0] s_adr,
   output logic [DATA_LENGTH-1:0]    s_wdata,
   input  logic [DATA_LENGTH-1:0]    s_rdata,
   input  logic                      s_ack,
   output logic [1:0]                grant
);

   // A zero TIMEOUT disables the watchdog but still needs a legal counter width.
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST_COUNT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                    state, state_next;
   logic                      last_grant, last_grant_next;
   logic [CW-1:0]             count, count_next;
   logic                      winner;
   logic                      s_cyc_next, s_we_next;
   logic [ADDRESS_LENGTH-1:0] s_adr_next;
   logic [DATA_LENGTH-1:0]    s_wdata_next;
   logic [1:0]                grant_next;
   logic                      m0_ack_next, m0_err_next, m1_ack_next, m1_err_next;
   logic [DATA_LENGTH-1:0]    m0_rdata_next, m1_rdata_next;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         count      <= '0;
         s_cyc      <= 1'b0;
         s_we       <= 1'b0;
         s_adr      <= '0;
         s_wdata    <= '0;
         grant      <= 2'b00;
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
         count      <= count_next;
         s_cyc      <= s_cyc_next;
         s_we       <= s_we_next;
         s_adr      <= s_adr_next;
         s_wdata    <= s_wdata_next;
         grant      <= grant_next;
         m0_ack     <= m0_ack_next;
         m0_err     <= m0_err_next;
         m1_ack     <= m1_ack_next;
         m1_err     <= m1_err_next;
         m0_rdata   <= m0_rdata_next;
         m1_rdata   <= m1_rdata_next;
      end
   end

   // Every output is computed one cycle ahead here so that all ports leave a flop.
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      count_next      = count;
      winner          = 1'b0;
      s_cyc_next      = s_cyc;
      s_we_next       = s_we;
      s_adr_next      = s_adr;
      s_wdata_next    = s_wdata;
      grant_next      = grant;
      m0_ack_next     = 1'b0;
      m0_err_next     = 1'b0;
      m1_ack_next     = 1'b0;
      m1_err_next     = 1'b0;
      m0_rdata_next   = m0_rdata;
      m1_rdata_next   = m1_rdata;

      case (state)
         IDLE: begin
            if (m0_req || m1_req) begin
               winner          = (m0_req && m1_req) ? ~last_grant : m1_req;
               state_next      = BUSY;
               s_cyc_next      = 1'b1;
               grant_next      = winner ? 2'b10 : 2'b01;
               s_we_next       = winner ? m1_we : m0_we;
               s_adr_next      = winner ? m1_adr : m0_adr;
               s_wdata_next    = winner ? m1_wdata : m0_wdata;
               last_grant_next = winner;
               count_next      = '0;
            end
         end
         BUSY: begin
            // Ack is tested first so a late ack still beats an expiring watchdog.
            if (s_ack) begin
               state_next = RESP;
               s_cyc_next = 1'b0;
               grant_next = 2'b00;
               if (grant[1]) begin
                  m1_ack_next   = 1'b1;
                  m1_rdata_next = s_rdata;
               end else begin
                  m0_ack_next   = 1'b1;
                  m0_rdata_next = s_rdata;
               end
            end else if ((TIMEOUT != 0) && (count == LAST_COUNT)) begin
               state_next = RESP;
               s_cyc_next = 1'b0;
               grant_next = 2'b00;
               if (grant[1]) begin
                  m1_err_next = 1'b1;
               end else begin
                  m0_err_next = 1'b1;
               end
            end else if (count != {CW{1'b1}}) begin
               count_next = count + CW'(1);
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a fixed vector table, hand-built watchdog/race/reset
// sequences, then random traffic scored against a transaction-level model.
module tb_mem_bus_arbiter;

   localparam int TB_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_adr, m0_wdata, m1_adr, m1_wdata;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic        s_cyc, s_we, s_ack;
   logic [31:0] s_adr, s_wdata, s_rdata;
   logic [1:0]  grant;

   int checks = 0;
   int errors = 0;

   mem_bus_arbiter #(
      .ADDRESS_LENGTH(32),
      .DATA_LENGTH(32),
      .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .m0_req(m0_req),
      .m0_we(m0_we),
      .m0_adr(m0_adr),
      .m0_wdata(m0_wdata),
      .m0_rdata(m0_rdata),
      .m0_ack(m0_ack),
      .m0_err(m0_err),
      .m1_req(m1_req),
      .m1_we(m1_we),
      .m1_adr(m1_adr),
      .m1_wdata(m1_wdata),
      .m1_rdata(m1_rdata),
      .m1_ack(m1_ack),
      .m1_err(m1_err),
      .s_cyc(s_cyc),
      .s_we(s_we),
      .s_adr(s_adr),
      .s_wdata(s_wdata),
      .s_rdata(s_rdata),
      .s_ack(s_ack),
      .grant(grant)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        rst_n;
      logic        r0;
      logic        r1;
      logic        ack;
      logic [31:0] rdata;
      logic        cyc;
      logic [1:0]  gnt;
      logic        a0;
      logic        a1;
      logic        e0;
      logic        e1;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } vec_t;

   vec_t vecs [16];

   // Transaction-level reference: who owns the bus, who is being answered, what data.
   int          mdl_owner;
   int          mdl_resp;
   int          mdl_elapsed;
   int          mdl_last;
   logic        mdl_resp_err;
   logic [31:0] mdl_rdata [2];
   logic        mdl_we;
   logic [31:0] mdl_adr, mdl_wdata;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      reset   = v.rst_n;
      m0_req  = v.r0;
      m1_req  = v.r1;
      s_ack   = v.ack;
      s_rdata = v.rdata;
   endtask

   task automatic model_reset();
      mdl_owner    = -1;
      mdl_resp     = -1;
      mdl_elapsed  = 0;
      mdl_last     = 1;
      mdl_resp_err = 1'b0;
      mdl_rdata[0] = '0;
      mdl_rdata[1] = '0;
      mdl_we       = 1'b0;
      mdl_adr      = '0;
      mdl_wdata    = '0;
   endtask

   // Called right after an edge, while the inputs of the cycle just ended are still driven.
   task automatic model_advance();
      if (!reset) begin
         model_reset();
      end else if (mdl_resp >= 0) begin
         mdl_resp = -1;
      end else if (mdl_owner >= 0) begin
         if (s_ack) begin
            mdl_rdata[mdl_owner] = s_rdata;
            mdl_resp     = mdl_owner;
            mdl_resp_err = 1'b0;
            mdl_owner    = -1;
         end else if (mdl_elapsed + 1 == TB_TIMEOUT) begin
            mdl_resp     = mdl_owner;
            mdl_resp_err = 1'b1;
            mdl_owner    = -1;
         end else begin
            mdl_elapsed++;
         end
      end else if (m0_req || m1_req) begin
         mdl_owner   = (m0_req && m1_req) ? 1 - mdl_last : (m1_req ? 1 : 0);
         mdl_last    = mdl_owner;
         mdl_elapsed = 0;
         mdl_we      = (mdl_owner == 1) ? m1_we : m0_we;
         mdl_adr     = (mdl_owner == 1) ? m1_adr : m0_adr;
         mdl_wdata   = (mdl_owner == 1) ? m1_wdata : m0_wdata;
      end
   endtask

   task automatic model_compare();
      logic [1:0] exp_gnt;
      exp_gnt = (mdl_owner == 0) ? 2'b01 : ((mdl_owner == 1) ? 2'b10 : 2'b00);
      checkOutput("rnd s_cyc", 64'(s_cyc), 64'(mdl_owner >= 0));
      checkOutput("rnd grant", 64'(grant), 64'(exp_gnt));
      checkOutput("rnd m0_ack", 64'(m0_ack), 64'(mdl_resp == 0 && !mdl_resp_err));
      checkOutput("rnd m1_ack", 64'(m1_ack), 64'(mdl_resp == 1 && !mdl_resp_err));
      checkOutput("rnd m0_err", 64'(m0_err), 64'(mdl_resp == 0 && mdl_resp_err));
      checkOutput("rnd m1_err", 64'(m1_err), 64'(mdl_resp == 1 && mdl_resp_err));
      checkOutput("rnd m0_rdata", 64'(m0_rdata), 64'(mdl_rdata[0]));
      checkOutput("rnd m1_rdata", 64'(m1_rdata), 64'(mdl_rdata[1]));
      if (mdl_owner >= 0) begin
         checkOutput("rnd s_we", 64'(s_we), 64'(mdl_we));
         checkOutput("rnd s_adr", 64'(s_adr), 64'(mdl_adr));
         checkOutput("rnd s_wdata", 64'(s_wdata), 64'(mdl_wdata));
      end
   endtask

   initial begin
      int busy_cycles;

      reset = 1'b0;
      m0_req = 1'b0; m0_we = 1'b0; m0_adr = 32'h100; m0_wdata = 32'h11;
      m1_req = 1'b0; m1_we = 1'b1; m1_adr = 32'h200; m1_wdata = 32'h22;
      s_ack = 1'b0; s_rdata = '0;

      //            rst r0 r1 ack rdata          cyc gnt   a0 a1 e0 e1 rd0            rd1
      vecs[0]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
      vecs[1]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
      vecs[2]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,32'h0,        32'h0};
      vecs[3]  = '{1'b1,1'b1,1'b1,1'b1,32'hA0A0A0A0, 1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,32'hA0A0A0A0, 32'h0};
      vecs[4]  = '{1'b1,1'b1,1'b1,1'b1,32'h55555555, 1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,32'hA0A0A0A0, 32'h0};
      vecs[5]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,32'hA0A0A0A0, 32'h0};
      vecs[6]  = '{1'b1,1'b1,1'b1,1'b1,32'hC0C0C0C0, 1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,32'hA0A0A0A0, 32'hC0C0C0C0};
      vecs[7]  = '{1'b1,1'b1,1'b1,1'b0,32'h0,        1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,32'hA0A0A0A0, 32'hC0C0C0C0};
      vecs[8]  = '{1'b1,1'b1,1'b1,1'b1,32'h66666666, 1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,32'hA0A0A0A0, 32'hC0C0C0C0};
      vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,32'hB0B0B0B0, 1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,32'hB0B0B0B0, 32'hC0C0C0C0};
      vecs[10] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,32'hB0B0B0B0, 32'hC0C0C0C0};
      vecs[11] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,32'hB0B0B0B0, 32'hC0C0C0C0};
      vecs[12] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,32'hB0B0B0B0, 32'hC0C0C0C0};
      vecs[13] = '{1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,32'hB0B0B0B0, 32'hC0C0C0C0};
      vecs[14] = '{1'b1,1'b1,1'b0,1'b1,32'hDEADBEEF, 1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,32'hDEADBEEF, 32'hC0C0C0C0};
      vecs[15] = '{1'b1,1'b0,1'b0,1'b0,32'h0,        1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,32'hDEADBEEF, 32'hC0C0C0C0};

      $display("[TB] vector table");
      for (int i = 0; i < 16; i++) begin
         applyStimulus(vecs[i]);
         step();
         checkOutput($sformatf("vec%0d s_cyc", i), 64'(s_cyc), 64'(vecs[i].cyc));
         checkOutput($sformatf("vec%0d grant", i), 64'(grant), 64'(vecs[i].gnt));
         checkOutput($sformatf("vec%0d m0_ack", i), 64'(m0_ack), 64'(vecs[i].a0));
         checkOutput($sformatf("vec%0d m1_ack", i), 64'(m1_ack), 64'(vecs[i].a1));
         checkOutput($sformatf("vec%0d m0_err", i), 64'(m0_err), 64'(vecs[i].e0));
         checkOutput($sformatf("vec%0d m1_err", i), 64'(m1_err), 64'(vecs[i].e1));
         checkOutput($sformatf("vec%0d m0_rdata", i), 64'(m0_rdata), 64'(vecs[i].rd0));
         checkOutput($sformatf("vec%0d m1_rdata", i), 64'(m1_rdata), 64'(vecs[i].rd1));
         if (vecs[i].gnt == 2'b01) begin
            checkOutput($sformatf("vec%0d s_adr", i), 64'(s_adr), 64'h100);
            checkOutput($sformatf("vec%0d s_we", i), 64'(s_we), 64'h0);
         end else if (vecs[i].gnt == 2'b10) begin
            checkOutput($sformatf("vec%0d s_adr", i), 64'(s_adr), 64'h200);
            checkOutput($sformatf("vec%0d s_wdata", i), 64'(s_wdata), 64'h22);
         end
      end

      $display("[TB] watchdog timeout");
      m1_adr = 32'h300; m1_wdata = 32'h33; m1_req = 1'b1; s_ack = 1'b0;
      step();
      checkOutput("tmo grant", 64'(grant), 64'h2);
      busy_cycles = 0;
      for (int i = 0; i < 20 && s_cyc; i++) begin
         busy_cycles++;
         step();
      end
      checkOutput("tmo busy cycles", 64'(busy_cycles), 64'(TB_TIMEOUT));
      checkOutput("tmo m1_err", 64'(m1_err), 64'h1);
      checkOutput("tmo m1_ack", 64'(m1_ack), 64'h0);
      checkOutput("tmo m0_err", 64'(m0_err), 64'h0);
      checkOutput("tmo m1_rdata", 64'(m1_rdata), 64'hC0C0C0C0);
      m1_req = 1'b0;
      step();
      checkOutput("tmo err pulse", 64'(m1_err), 64'h0);

      $display("[TB] ack versus timeout race");
      m0_adr = 32'h400; m0_req = 1'b1;
      step();
      repeat (3) step();
      checkOutput("race busy4 s_cyc", 64'(s_cyc), 64'h1);
      s_ack = 1'b1; s_rdata = 32'h12345678;
      step();
      s_ack = 1'b0; m0_req = 1'b0;
      checkOutput("race m0_ack", 64'(m0_ack), 64'h1);
      checkOutput("race m0_err", 64'(m0_err), 64'h0);
      checkOutput("race m0_rdata", 64'(m0_rdata), 64'h12345678);
      step();

      $display("[TB] reset during busy");
      m1_req = 1'b1;
      step();
      checkOutput("rstbusy grant", 64'(grant), 64'h2);
      reset = 1'b0; s_ack = 1'b1; s_rdata = 32'h99;
      step();
      checkOutput("rstbusy m1_ack", 64'(m1_ack), 64'h0);
      checkOutput("rstbusy s_cyc", 64'(s_cyc), 64'h0);
      checkOutput("rstbusy grant0", 64'(grant), 64'h0);
      checkOutput("rstbusy m0_rdata", 64'(m0_rdata), 64'h0);
      checkOutput("rstbusy s_adr", 64'(s_adr), 64'h0);
      reset = 1'b1; s_ack = 1'b0; m1_req = 1'b0;
      step();
      checkOutput("rstbusy after m1_ack", 64'(m1_ack), 64'h0);
      checkOutput("rstbusy after grant", 64'(grant), 64'h0);

      $display("[TB] random traffic");
      reset = 1'b0;
      step();
      model_reset();
      reset = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         step();
         model_advance();
         model_compare();
         if (m0_req && (m0_ack || m0_err)) begin
            m0_req = 1'b0;
         end else if (!m0_req && ($urandom % 4 == 0)) begin
            m0_req = 1'b1; m0_we = 1'($urandom); m0_adr = $urandom; m0_wdata = $urandom;
         end
         if (m1_req && (m1_ack || m1_err)) begin
            m1_req = 1'b0;
         end else if (!m1_req && ($urandom % 4 == 0)) begin
            m1_req = 1'b1; m1_we = 1'($urandom); m1_adr = $urandom; m1_wdata = $urandom;
         end
         s_ack   = s_cyc ? ($urandom % 3 == 0) : ($urandom % 8 == 0);
         s_rdata = $urandom;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
